instr_encoder: RTL
==================

# instr_encoder

Field-level RV32I instruction encoder feeding the `decoder` block. It accepts instruction requests as register, funct and immediate fields over a valid/ready handshake and packs each into a 32-bit RV32I word. It also expands the `li` pseudo-instruction into LUI+ADDI. Encoded words are buffered in a small FIFO and presented on `instruction_o` with a valid/ready handshake. It serves as the instruction source for the decoder and as stimulus for core bring-up.

## Interface
- `DEPTH`, default 2: output FIFO entries; power of two, ≥2.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_kind_i`  in  3  request kind: 0 RR (0110011), 1 I_OP (0010011), 2 LOAD (0000011), 3 STORE (0100011), 4 LI pseudo; 5–7 illegal.
- `req_funct3_i`  in  3  funct3; ignored for LI.
- `req_funct7_i`  in  7  funct7; used only for RR.
- `req_rd_i`, `req_rs1_i`, `req_rs2_i`  in  5 each  register indices.
- `req_imm_i`  in  32  signed immediate.
- `instruction_o`  out  32  FIFO head word; 0x00000013 (NOP) whenever `instr_valid_o`=0.
- `instr_valid_o`  out  1  head valid (count≠0).
- `instr_ready_i`  in  1  consumer accepts head.
- `err_o`  out  1  one-cycle pulse: the previous accepted request was illegal.
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Encoding:**
  - RR: {funct7, rs2, rs1, funct3, rd, op}.
  - I_OP/LOAD: {imm[11:0], rs1, funct3, rd, op}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- **Immediate range:** for I_OP/LOAD/STORE, `req_imm_i` must equal the sign-extension of its bits [11:0]. If not, the request is illegal.
- **Illegal request:** accepted (handshake completes), nothing enqueued, `err_o` pulses.
- **LI:**
  - If imm fits 12 bits signed, emit a single ADDI rd,x0,imm[11:0].
  - Otherwise lo=imm[11:0] and hi=(imm+0x800)[31:12], modulo 2^32.
  - Emit LUI rd,hi (op 0110111), then ADDI rd,rd,lo. The ADDI is omitted when lo=0.
- **FSM:**
  - IDLE: `req_ready_o` = !full. On accept, enqueue the single word, or enqueue the LUI and go to LI_LO (latch rd and lo).
  - LI_LO: `req_ready_o`=0. Enqueue the ADDI when !full, then return to IDLE.
- **FIFO:** circular, DEPTH entries.
  - Pointers wrap modulo DEPTH.
  - Enqueue and dequeue in the same cycle leaves count unchanged.
  - No enqueue when full, even if a dequeue occurs in that cycle: `req_ready_o` and LI_LO progress depend only on the registered count.
- **Reset (async):**
  - State→IDLE, count→0, pointers→0.
  - `instr_valid_o`=0, `instruction_o`=0x00000013, `err_o`=0, `count_o`=0.
  - `req_ready_o`=1 combinationally once reset is released.
  - A pending LI_LO is discarded.

## Timing
- Request accepted at edge N → word visible on `instruction_o` with `instr_valid_o`=1 after edge N (registered, latency 1).
- Two-word LI: LUI visible after edge N; ADDI enqueued at edge N+1 if space; `req_ready_o` low during cycle N+1.
- `err_o` high for exactly the cycle following the accepting edge.
- Dequeue at edge M: the next head (or NOP) appears after edge M.
- `req_ready_o` is combinational from state and count only; it is never a function of `req_valid_i`.

## Configuration
- Macro `INSTR_ENC_LI_EXPAND_EN`.
- **Defined:** LI (kind 4) is supported as described above, including the LI_LO state.
- **Undefined:** the LI_LO state is absent; kind 4 is illegal (accepted, nothing enqueued, `err_o` pulse); all other kinds are unchanged.

## Test plan
1. RR kind, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 → `instruction_o`=0x002081B3, `instr_valid_o`=1 one cycle after accept.
2. I_OP addi, rd=1, rs1=0, imm=12 → 0x00C00093. LOAD funct3=101, rd=2, rs1=1, imm=12 → 0x00C0D103.
3. STORE funct3=010, rs2=2, rs1=1, imm=-4 → 0xFE20AE23. I_OP imm=2048 → `err_o` pulse, count stays 0.
4. LI rd=5, imm=0x12345FFF, `instr_ready_i`=0 → FIFO holds 0x123462B7 then 0xFFF28293. `req_ready_o`=0 during LI_LO, then 0 while full (count=2). Release `instr_ready_i` → words drain in order, then `instruction_o`=0x00000013.
5. LI rd=5, imm=0x00005000 → single LUI 0x000052B7. LI imm=-1 → single ADDI 0xFFF00293. Without the macro, kind 4 → `err_o` pulse, nothing enqueued.
6. Assert `rst` asynchronously while in LI_LO with FIFO non-empty → immediately `instr_valid_o`=0, `count_o`=0, `instruction_o`=0x00000013. After release, `req_ready_o`=1 and no stale ADDI emerges.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction requests (register/funct/immediate
// fields) into 32-bit words and buffers them in a small circular FIFO.
//
// Optional feature macro: INSTR_ENC_LI_EXPAND_EN
//   defined   - kind 4 (LI pseudo) expands to ADDI, LUI, or LUI+ADDI
//   undefined - kind 4 is treated as an illegal request
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   req_valid_i/ready_o request handshake
//   req_kind_i          0 RR, 1 I_OP, 2 LOAD, 3 STORE, 4 LI, 5-7 illegal
//   req_funct3_i/7_i    funct fields
//   req_rd/rs1/rs2_i    register indices
//   req_imm_i           signed 32-bit immediate
//   instruction_o       FIFO head word, NOP (0x00000013) when empty
//   instr_valid_o       FIFO non-empty
//   instr_ready_i       consumer accepts head
//   err_o               pulse: previous accepted request was illegal
//   count_o             FIFO occupancy
module instr_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [2:0]                 req_kind_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [6:0]                 req_funct7_i,
  input  logic [4:0]                 req_rd_i,
  input  logic [4:0]                 req_rs1_i,
  input  logic [4:0]                 req_rs2_i,
  input  logic [31:0]                req_imm_i,
  output logic [31:0]                instruction_o,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [6:0]  OP_RR    = 7'b0110011;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   push_word;
  logic          err_next;
  logic          err_q;
  logic          imm_ok;

  // Immediate must be the sign-extension of its low 12 bits
  assign imm_ok = (req_imm_i == {{20{req_imm_i[11]}}, req_imm_i[11:0]});
  assign full   = (count == CW'(DEPTH));
  assign pop    = (count != '0) && instr_ready_i;

`ifdef INSTR_ENC_LI_EXPAND_EN
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  li_rd;
  logic [4:0]  li_rd_next;
  logic [11:0] li_lo;
  logic [11:0] li_lo_next;
  logic [19:0] li_hi;

  // (imm + 0x800) >> 12: the carry out of the low 12 bits is simply imm[11]
  assign li_hi = req_imm_i[31:12] + 20'(req_imm_i[11]);

  // State register plus latched rd/lo for the pending ADDI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      li_rd <= '0;
      li_lo <= '0;
    end else begin
      state <= state_next;
      li_rd <= li_rd_next;
      li_lo <= li_lo_next;
    end
  end
`endif

  // Next-state, request acceptance and word encoding
  always_comb begin
    push      = 1'b0;
    push_word = NOP_WORD;
    err_next  = 1'b0;
`ifdef INSTR_ENC_LI_EXPAND_EN
    state_next  = state;
    li_rd_next  = li_rd;
    li_lo_next  = li_lo;
    req_ready_o = (state == IDLE) && !full;
    if (state == LI_LO && !full) begin
      push       = 1'b1;
      push_word  = {li_lo, li_rd, 3'b000, li_rd, OP_IMM};
      state_next = IDLE;
    end
`else
    req_ready_o = !full;
`endif
    accept = req_valid_i && req_ready_o;
    if (accept) begin
      case (req_kind_i)
        3'd0: begin
          push      = 1'b1;
          push_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, OP_RR};
        end
        3'd1, 3'd2: begin
          if (imm_ok) begin
            push      = 1'b1;
            push_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i,
                         (req_kind_i == 3'd1) ? OP_IMM : OP_LOAD};
          end else begin
            err_next = 1'b1;
          end
        end
        3'd3: begin
          if (imm_ok) begin
            push      = 1'b1;
            push_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                         req_imm_i[4:0], OP_STORE};
          end else begin
            err_next = 1'b1;
          end
        end
`ifdef INSTR_ENC_LI_EXPAND_EN
        3'd4: begin
          push = 1'b1;
          if (imm_ok) begin
            push_word = {req_imm_i[11:0], 5'd0, 3'b000, req_rd_i, OP_IMM};
          end else begin
            push_word = {li_hi, req_rd_i, OP_LUI};
            // ADDI is skipped when the low part is zero
            if (req_imm_i[11:0] != 12'd0) begin
              state_next = LI_LO;
              li_rd_next = req_rd_i;
              li_lo_next = req_imm_i[11:0];
            end
          end
        end
`endif
        default: err_next = 1'b1;
      endcase
    end
  end

  // FIFO storage (contents only read while count != 0)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      err_q <= err_next;
    end
  end

  assign instr_valid_o = (count != '0);
  assign instruction_o = (count != '0) ? mem[rd_ptr] : NOP_WORD;
  assign err_o         = err_q;
  assign count_o       = count;

endmodule
